mem_arbiter: RTL and testbench

Two-port arbiter sharing the single memory controller between the CPU sequencer (`ctrl`) and a debug/loader port. It accepts one request at a time and latches the winner's op, address and write data. It forwards these to the memory controller and holds them until `mem_op_done`, then returns read data with a one-cycle done pulse to the winning requester. It sits between `ctrl`/debug logic and the memory controller and is the only driver of the memory controller's op/address/data inputs.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/debug memory arbiter: memory controller op codes,
// arbiter FSM states and port ownership.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_ctrl_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } mem_arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } mem_arb_owner_e;

  function automatic logic is_request(input mem_ctrl_op_e op);
    return (op != OP_IDLE);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of the single memory controller.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on simultaneous requests).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset,

  input  mem_ctrl_op_e              cpu_op,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_wdata,
  output logic [DATA_BUS_WIDTH-1:0] cpu_rdata,
  output logic                      cpu_done,

  input  mem_ctrl_op_e              dbg_op,
  input  logic [ADDR_WIDTH-1:0]     dbg_addr,
  input  logic [DATA_BUS_WIDTH-1:0] dbg_wdata,
  output logic [DATA_BUS_WIDTH-1:0] dbg_rdata,
  output logic                      dbg_done,

  output mem_ctrl_op_e              mem_op,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  input  logic                      mem_op_done,

  output logic                      grant,
  output logic                      busy
);

  mem_arb_state_e            r_state;
  mem_arb_state_e            w_next_state;
  mem_arb_owner_e            w_winner;
  logic                      w_cpu_req;
  logic                      w_dbg_req;
  logic                      w_any_req;

  mem_ctrl_op_e              r_mem_op;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_BUS_WIDTH-1:0] r_mem_wdata;
  logic [DATA_BUS_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_BUS_WIDTH-1:0] r_dbg_rdata;
  logic                      r_cpu_done;
  logic                      r_dbg_done;
  mem_arb_owner_e            r_grant;
  logic                      r_busy;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the debug port took the most recent grant; resets to 1 so the CPU wins first.
  logic                      r_last_dbg;
`endif

  assign w_cpu_req = is_request(cpu_op);
  assign w_dbg_req = is_request(dbg_op);
  assign w_any_req = w_cpu_req | w_dbg_req;

  always_comb begin
    w_winner = OWNER_CPU;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (w_cpu_req && w_dbg_req) begin
      w_winner = r_last_dbg ? OWNER_CPU : OWNER_DBG;
    end else if (w_dbg_req) begin
      w_winner = OWNER_DBG;
    end
`else
    if (!w_cpu_req && w_dbg_req) begin
      w_winner = OWNER_DBG;
    end
`endif
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = BUSY;
      BUSY:    if (mem_op_done) w_next_state = RELEASE;
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // mem_op_done outside BUSY falls through untouched, so it is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_op    <= OP_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
      r_grant     <= OWNER_CPU;
      r_busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_dbg  <= 1'b1;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            if (w_winner == OWNER_DBG) begin
              r_mem_op    <= dbg_op;
              r_mem_addr  <= dbg_addr;
              r_mem_wdata <= dbg_wdata;
            end else begin
              r_mem_op    <= cpu_op;
              r_mem_addr  <= cpu_addr;
              r_mem_wdata <= cpu_wdata;
            end
            r_grant <= w_winner;
            r_busy  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_dbg <= (w_winner == OWNER_DBG);
`endif
          end
        end
        BUSY: begin
          if (mem_op_done) begin
            r_mem_op <= OP_IDLE;
            if (r_grant == OWNER_DBG) begin
              r_dbg_done <= 1'b1;
              if (r_mem_op == OP_READ) r_dbg_rdata <= mem_rdata;
            end else begin
              r_cpu_done <= 1'b1;
              if (r_mem_op == OP_READ) r_cpu_rdata <= mem_rdata;
            end
          end
        end
        RELEASE: begin
          r_cpu_done <= 1'b0;
          r_dbg_done <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_mem_op   <= OP_IDLE;
          r_cpu_done <= 1'b0;
          r_dbg_done <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_op    = r_mem_op;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_done  = r_cpu_done;
  assign dbg_done  = r_dbg_done;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected grant order follows
// MEM_ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clock;
  logic          reset;
  mem_ctrl_op_e  cpu_op;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  mem_ctrl_op_e  dbg_op;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;
  mem_ctrl_op_e  mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_op_done;
  logic          grant;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.DATA_BUS_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_op_done(mem_op_done),
    .grant(grant), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    cpu_op      = OP_IDLE; cpu_addr = '0; cpu_wdata = '0;
    dbg_op      = OP_IDLE; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata   = '0;
    mem_op_done = 1'b0;
    #2 reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (mem_op !== OP_IDLE || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
          cpu_rdata !== 8'h00 || dbg_rdata !== 8'h00 || cpu_done !== 1'b0 ||
          dbg_done !== 1'b0 || grant !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: got op=%0d addr=%h wd=%h crd=%h drd=%h cd=%b dd=%b g=%b b=%b, need all zero",
                 i, mem_op, mem_addr, mem_wdata, cpu_rdata, dbg_rdata, cpu_done, dbg_done, grant, busy);
      end
    end
  endtask

  task automatic test_cpu_read();
    cpu_op = OP_READ; cpu_addr = 8'h3C;
    tick();
    total++;
    if (mem_op !== OP_READ || mem_addr !== 8'h3C || grant !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cpu_read_issue: got op=%0d addr=%h g=%b b=%b, need op=1 addr=3c g=0 b=1",
               mem_op, mem_addr, grant, busy);
    end
    tick();
    total++;
    if (cpu_done !== 1'b0 || mem_op !== OP_READ) begin
      bad++;
      $display("[TB] FAIL cpu_read_wait: got cd=%b op=%0d, need cd=0 op=1", cpu_done, mem_op);
    end
    mem_op_done = 1'b1; mem_rdata = 8'hA5;
    tick();
    total++;
    if (cpu_rdata !== 8'hA5 || cpu_done !== 1'b1 || dbg_done !== 1'b0 || mem_op !== OP_IDLE || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cpu_read_done: got rd=%h cd=%b dd=%b op=%0d b=%b, need rd=a5 cd=1 dd=0 op=0 b=1",
               cpu_rdata, cpu_done, dbg_done, mem_op, busy);
    end
    mem_op_done = 1'b0; cpu_op = OP_IDLE;
    tick();
    total++;
    if (cpu_done !== 1'b0 || dbg_done !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL cpu_read_release: got cd=%b dd=%b b=%b rd=%h, need cd=0 dd=0 b=0 rd=a5",
               cpu_done, dbg_done, busy, cpu_rdata);
    end
  endtask

  task automatic test_dbg_write();
    dbg_op = OP_WRITE; dbg_addr = 8'h10; dbg_wdata = 8'h5A;
    tick();
    total++;
    if (mem_op !== OP_WRITE || mem_addr !== 8'h10 || mem_wdata !== 8'h5A || grant !== 1'b1) begin
      bad++;
      $display("[TB] FAIL dbg_write_issue: got op=%0d addr=%h wd=%h g=%b, need op=2 addr=10 wd=5a g=1",
               mem_op, mem_addr, mem_wdata, grant);
    end
    mem_op_done = 1'b1; mem_rdata = 8'hEE;
    tick();
    total++;
    if (dbg_done !== 1'b1 || cpu_done !== 1'b0 || dbg_rdata !== 8'h00 || cpu_rdata !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL dbg_write_done: got dd=%b cd=%b drd=%h crd=%h, need dd=1 cd=0 drd=00 crd=a5",
               dbg_done, cpu_done, dbg_rdata, cpu_rdata);
    end
    mem_op_done = 1'b0; dbg_op = OP_IDLE;
    tick();
    total++;
    if (dbg_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dbg_write_release: got dd=%b b=%b, need dd=0 b=0", dbg_done, busy);
    end
  endtask

  task automatic test_both_read();
    logic expGrant;
    logic [DW-1:0] expData;
    cpu_op = OP_READ; cpu_addr = 8'h01;
    dbg_op = OP_READ; dbg_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expGrant = i[0];
`else
      expGrant = 1'b0;
`endif
      expData = 8'h40 + 8'(i);
      tick();
      total++;
      if (grant !== expGrant || mem_addr !== (expGrant ? 8'h02 : 8'h01) || mem_op !== OP_READ) begin
        bad++;
        $display("[TB] FAIL both_grant %0d: got g=%b addr=%h op=%0d, need g=%b addr=%h op=1",
                 i, grant, mem_addr, mem_op, expGrant, expGrant ? 8'h02 : 8'h01);
      end
      mem_op_done = 1'b1; mem_rdata = expData;
      tick();
      total++;
      if (cpu_done !== !expGrant || dbg_done !== expGrant ||
          (expGrant ? dbg_rdata : cpu_rdata) !== expData) begin
        bad++;
        $display("[TB] FAIL both_done %0d: got cd=%b dd=%b crd=%h drd=%h, need cd=%b dd=%b winner rd=%h",
                 i, cpu_done, dbg_done, cpu_rdata, dbg_rdata, !expGrant, expGrant, expData);
      end
      mem_op_done = 1'b0;
      if (i == 3) begin
        cpu_op = OP_IDLE; dbg_op = OP_IDLE;
      end
      tick();
    end
  endtask

  task automatic test_addr_hold();
    cpu_op = OP_READ; cpu_addr = 8'h3C;
    tick();
    cpu_addr = 8'h77; cpu_op = OP_WRITE; cpu_wdata = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (mem_addr !== 8'h3C || mem_op !== OP_READ) begin
        bad++;
        $display("[TB] FAIL addr_hold %0d: got addr=%h op=%0d, need addr=3c op=1", i, mem_addr, mem_op);
      end
    end
    mem_op_done = 1'b1; mem_rdata = 8'h99;
    tick();
    total++;
    if (cpu_rdata !== 8'h99 || cpu_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL addr_hold_done: got rd=%h cd=%b, need rd=99 cd=1", cpu_rdata, cpu_done);
    end
    mem_op_done = 1'b0; cpu_op = OP_IDLE;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    cpu_op = OP_READ; cpu_addr = 8'h20;
    tick();
    total++;
    if (busy !== 1'b1 || mem_op !== OP_READ) begin
      bad++;
      $display("[TB] FAIL midreset_busy: got b=%b op=%0d, need b=1 op=1", busy, mem_op);
    end
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || mem_op !== OP_IDLE || cpu_rdata !== 8'h00 || cpu_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_async: got b=%b op=%0d rd=%h cd=%b, need b=0 op=0 rd=00 cd=0",
               busy, mem_op, cpu_rdata, cpu_done);
    end
    cpu_op = OP_IDLE;
    tick();
    reset = 1'b1;
    mem_op_done = 1'b1; mem_rdata = 8'hCC;
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_op_done = 1'b0;
      total++;
      if (cpu_done !== 1'b0 || dbg_done !== 1'b0 || mem_op !== OP_IDLE ||
          cpu_rdata !== 8'h00 || dbg_rdata !== 8'h00 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midreset_spurious %0d: got cd=%b dd=%b op=%0d crd=%h drd=%h b=%b, need all zero",
                 i, cpu_done, dbg_done, mem_op, cpu_rdata, dbg_rdata, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_both_read();
    test_addr_hold();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
